// File: rtl/aura16_pkg.sv
// Shared definitions for the aura16 pipeline: PC width, branch-table geometry,
// 2-bit predictor counter encodings and the EX branch slot record.
package aura16_pkg;

  localparam int unsigned PC_W  = 16;
  localparam int unsigned IDX_W = 4;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic             pred;
    logic             bnq;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  fallthrough;
  } slot_t;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter used as one branch-history table entry.
// Resets to weakly-not-taken.
module sat_counter2
  import aura16_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  output logic [1:0] cnt
);

  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (up && (cnt_q != ST)) begin
        cnt_d = cnt_q + 2'd1;
      end else if (!up && (cnt_q != SNT)) begin
        cnt_d = cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= WNT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch predictor and redirect controller: predicts BEQ/BNQ in ID, resolves in EX,
// redirects/flushes on mispredict, trains the counter table and keeps perf counters.
module branch_predict_ctrl
  import aura16_pkg::*;
#(
  parameter int unsigned PC_INC = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic             id_bnq,
  input  logic [PC_W-1:0]  id_pc,
  input  logic [PC_W-1:0]  id_target,
  input  logic             stall,
  input  logic             ex_zero,
  output logic             id_redirect,
  output logic             ex_redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int NumEnt = 2 ** IDX_W;

  logic [NumEnt-1:0][1:0] ctr;
  logic [NumEnt-1:0]      train_en;
  logic [IDX_W-1:0]       id_idx;
  logic                   id_br;
  logic                   pred;
  logic                   taken;
  slot_t                  slot_q, slot_d;
  logic [CNT_W-1:0]       branch_q, branch_d;
  logic [CNT_W-1:0]       mispred_q, mispred_d;

  // Counter table; lookups see the pre-update value when training hits the same entry.
  for (genvar i = 0; i < NumEnt; i++) begin : g_ctr
    sat_counter2 u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (train_en[i]),
      .up    (taken),
      .cnt   (ctr[i])
    );
  end

  assign id_idx = id_pc[IDX_W:1];
  assign id_br  = id_valid & (id_branch | id_bnq);
  assign pred   = ctr[id_idx][1];

  assign taken       = slot_q.bnq ? ~ex_zero : ex_zero;
  assign ex_redirect = slot_q.valid & (taken != slot_q.pred);
  // EX correction wins: the ID instruction is on the wrong path.
  assign id_redirect = id_br & pred & ~stall & ~ex_redirect;

  assign flush_if_id = id_redirect | ex_redirect;
  assign flush_id_ex = ex_redirect;

  always_comb begin
    redirect_pc = '0;
    if (ex_redirect) begin
      redirect_pc = taken ? slot_q.target : slot_q.fallthrough;
    end else if (id_redirect) begin
      redirect_pc = id_target;
    end
  end

  always_comb begin
    train_en = '0;
    if (slot_q.valid) begin
      train_en[slot_q.idx] = 1'b1;
    end
  end

  always_comb begin
    slot_d = '0;
    if (id_br && !stall && !ex_redirect) begin
      slot_d.valid       = 1'b1;
      slot_d.idx         = id_idx;
      slot_d.pred        = pred;
      slot_d.bnq         = id_bnq;
      slot_d.target      = id_target;
      slot_d.fallthrough = id_pc + PC_W'(PC_INC);
    end
  end

  always_comb begin
    branch_d  = branch_q;
    mispred_d = mispred_q;
    if (slot_q.valid) begin
      if (branch_q != '1) begin
        branch_d = branch_q + CNT_W'(1);
      end
      if (ex_redirect && (mispred_q != '1)) begin
        mispred_d = mispred_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q    <= '0;
      branch_q  <= '0;
      mispred_q <= '0;
    end else begin
      slot_q    <= slot_d;
      branch_q  <= branch_d;
      mispred_q <= mispred_d;
    end
  end

  assign branch_count     = branch_q;
  assign mispredict_count = mispred_q;

endmodule
